// File: rtl/cache_pkg.sv
// Shared constants and types for the cache and its backing memory.
// Request field positions describe the default 16-bit byte address layout.
package cache_pkg;

   localparam int WE_BIT      = 24;
   localparam int DATA_MSB    = 23;
   localparam int DATA_LSB    = 16;
   localparam int ADDR_MSB    = 15;
   localparam int REQ_WIDTH   = 25;
   localparam int BLOCK_WIDTH = 16;

   typedef enum logic [1:0] {
      CLEAR   = 2'd0,
      IDLE    = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } memState_t;

endpackage

// File: rtl/backing_memory_if.sv
// Memory port between the cache (master) and the backing memory (slave).
interface backing_memory_if
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
);

   logic [ADDR_WIDTH+8:0]  memory_request;
   logic                   memory_request_ready;
   logic [BLOCK_WIDTH-1:0] memory_response;
   logic                   memory_response_ready;
   logic                   memory_ready;

   modport master (
      output memory_request,
      output memory_request_ready,
      input  memory_response,
      input  memory_response_ready,
      input  memory_ready
   );

   modport slave (
      input  memory_request,
      input  memory_request_ready,
      output memory_response,
      output memory_response_ready,
      output memory_ready
   );

endinterface

// File: rtl/memory_array.sv
// Word store: one byte-enabled write port and one registered read port.
// A read of the word being written in the same cycle returns the new data,
// so a freshly accepted write is visible one edge later.
module memory_array
   import cache_pkg::*;
#(
   parameter int DEPTH = 32768,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   i_wrEn,
   input  logic [AW-1:0]          i_wrAddr,
   input  logic [1:0]             i_byteEn,
   input  logic [BLOCK_WIDTH-1:0] i_wrData,
   input  logic [AW-1:0]          i_rdAddr,
   output logic [BLOCK_WIDTH-1:0] o_rdData
);

   logic [BLOCK_WIDTH-1:0] r_mem [DEPTH];
   logic [BLOCK_WIDTH-1:0] r_rdData;
   logic [BLOCK_WIDTH-1:0] w_merged;

   // Store the enabled byte lanes of the incoming word
   always_ff @(posedge clock) begin
      if (i_wrEn) begin
         if (i_byteEn[0]) r_mem[i_wrAddr][7:0]  <= i_wrData[7:0];
         if (i_byteEn[1]) r_mem[i_wrAddr][15:8] <= i_wrData[15:8];
      end
   end

   // Forward same-cycle write lanes into the read word
   always_comb begin
      w_merged = r_mem[i_rdAddr];
      if (i_wrEn && (i_wrAddr == i_rdAddr)) begin
         if (i_byteEn[0]) w_merged[7:0]  = i_wrData[7:0];
         if (i_byteEn[1]) w_merged[15:8] = i_wrData[15:8];
      end
   end

   // Register the read word
   always_ff @(posedge clock) begin
      r_rdData <= w_merged;
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/backing_memory.sv
// Main-memory responder behind the cache. Commits byte writes on
// acceptance, waits LATENCY cycles and returns the whole 16-bit block.
// Optionally zero-fills the store after reset.
module backing_memory
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int LATENCY        = 4,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic             clock,
   input  logic             reset,
   backing_memory_if.slave  bus
);

   localparam int WORD_BITS = ADDR_WIDTH - 1;
   localparam int DEPTH     = 1 << WORD_BITS;

   memState_t              r_state;
   logic [WORD_BITS-1:0]   r_clearCount;
   logic [7:0]             r_latCount;
   logic [WORD_BITS-1:0]   r_wordAddr;
   logic [BLOCK_WIDTH-1:0] r_response;
   logic                   r_responseReady;
   logic                   r_memoryReady;

   logic                   w_reqWe;
   logic [7:0]             w_reqData;
   logic [ADDR_WIDTH-1:0]  w_reqAddr;
   logic                   w_accept;

   logic                   w_wrEn;
   logic [WORD_BITS-1:0]   w_wrAddr;
   logic [1:0]             w_byteEn;
   logic [BLOCK_WIDTH-1:0] w_wrData;
   logic [WORD_BITS-1:0]   w_rdAddr;
   logic [BLOCK_WIDTH-1:0] w_rdData;

   assign w_reqWe   = bus.memory_request[ADDR_WIDTH+8];
   assign w_reqData = bus.memory_request[ADDR_WIDTH+7:ADDR_WIDTH];
   assign w_reqAddr = bus.memory_request[ADDR_WIDTH-1:0];
   assign w_accept  = (r_state == IDLE) && bus.memory_request_ready;

   // Steer the store write port: zero-fill during CLEAR, byte write on acceptance
   always_comb begin
      w_wrEn   = 1'b0;
      w_wrAddr = r_clearCount;
      w_byteEn = 2'b11;
      w_wrData = '0;
      if (r_state == CLEAR) begin
         w_wrEn = 1'b1;
      end else if (w_accept && w_reqWe) begin
         w_wrEn   = 1'b1;
         w_wrAddr = w_reqAddr[ADDR_WIDTH-1:1];
         w_byteEn = w_reqAddr[0] ? 2'b10 : 2'b01;
         w_wrData = {w_reqData, w_reqData};
      end
   end

   // Read the incoming address while idle so even a one-cycle latency has data ready
   always_comb begin
      w_rdAddr = r_wordAddr;
      if (r_state == IDLE) w_rdAddr = w_reqAddr[ADDR_WIDTH-1:1];
   end

   memory_array #(
      .DEPTH (DEPTH),
      .AW    (WORD_BITS)
   ) u_array (
      .clock    (clock),
      .i_wrEn   (w_wrEn),
      .i_wrAddr (w_wrAddr),
      .i_byteEn (w_byteEn),
      .i_wrData (w_wrData),
      .i_rdAddr (w_rdAddr),
      .o_rdData (w_rdData)
   );

   // Request FSM with clear sweep, latency countdown and four-phase response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state         <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         r_clearCount    <= '0;
         r_latCount      <= '0;
         r_wordAddr      <= '0;
         r_response      <= '0;
         r_responseReady <= 1'b0;
         r_memoryReady   <= (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
      end else begin
         case (r_state)
            CLEAR: begin
               if (r_clearCount == WORD_BITS'(DEPTH - 1)) begin
                  r_state       <= IDLE;
                  r_memoryReady <= 1'b1;
               end else begin
                  r_clearCount <= r_clearCount + 1'b1;
               end
            end
            IDLE: begin
               if (w_accept) begin
                  r_wordAddr <= w_reqAddr[ADDR_WIDTH-1:1];
                  r_latCount <= 8'(LATENCY - 1);
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               if (!bus.memory_request_ready) begin
                  r_state <= IDLE;
               end else if (r_latCount == 8'd0) begin
                  r_response      <= w_rdData;
                  r_responseReady <= 1'b1;
                  r_state         <= RESPOND;
               end else begin
                  r_latCount <= r_latCount - 8'd1;
               end
            end
            RESPOND: begin
               if (!bus.memory_request_ready) begin
                  r_response      <= '0;
                  r_responseReady <= 1'b0;
                  r_state         <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.memory_response       = r_response;
   assign bus.memory_response_ready = r_responseReady;
   assign bus.memory_ready          = r_memoryReady;

endmodule
